// File: rtl/wd_window_sequencer.sv
// Windowed watchdog sequencer: IDLE -> CLOSED -> OPEN service window, sticky FAULT with delayed RSTREQ.
// Optional macro WD_FAULT_LOG_EN adds an 8-bit saturating FAULT-entry counter on FLTCNT.
module wd_window_sequencer #(
  parameter int CLOSED_CYC = 16,
  parameter int OPEN_CYC   = 32,
  parameter int RST_DLY    = 8
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       EN,
  input  logic       SWSTAT,
  input  logic       WDSRVC,
  input  logic       FWOVR,
  input  logic       CLRFLT,
  output logic       WDFAIL,
  output logic [2:0] FLSTAT,
  output logic [1:0] WSTATE,
  output logic       WINOPEN,
`ifdef WD_FAULT_LOG_EN
  output logic [7:0] FLTCNT,
`endif
  output logic       RSTREQ
);

  localparam int MAXA = (CLOSED_CYC > OPEN_CYC) ? CLOSED_CYC : OPEN_CYC;
  localparam int MAXC = (MAXA > RST_DLY) ? MAXA : RST_DLY;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] FC_OVR   = 3'b000;
  localparam logic [2:0] FC_SW    = 3'b001;
  localparam logic [2:0] FC_EARLY = 3'b010;
  localparam logic [2:0] FC_TMO   = 3'b011;
  localparam logic [2:0] FC_NONE  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CLOSED = 2'b01,
    S_OPEN   = 2'b10,
    S_FAULT  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            srv_q;
  logic            wdfail_q, wdfail_d;
  logic [2:0]      flstat_q, flstat_d;
  logic            rstreq_q, rstreq_d;
  logic            fired_q, fired_d;
  logic            srv_evt, flt_set;
  logic [2:0]      flt_code;

  assign srv_evt = WDSRVC & ~srv_q;

  always_comb begin
    state_d  = state_q;
    flt_set  = 1'b0;
    flt_code = FC_NONE;
    case (state_q)
      S_IDLE: begin
        if (FWOVR) begin
          flt_set = 1'b1; flt_code = FC_OVR;
        end else if (EN) begin
          state_d = S_CLOSED;
        end
      end
      S_CLOSED: begin
        if (FWOVR) begin
          flt_set = 1'b1; flt_code = FC_OVR;
        end else if (srv_evt) begin
          flt_set = 1'b1; flt_code = SWSTAT ? FC_EARLY : FC_SW;
        end else if (!EN) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(CLOSED_CYC - 1)) begin
          state_d = S_OPEN;
        end
      end
      S_OPEN: begin
        // a service on the terminal cycle is a kick, so it is tested before timeout
        if (FWOVR) begin
          flt_set = 1'b1; flt_code = FC_OVR;
        end else if (srv_evt && !SWSTAT) begin
          flt_set = 1'b1; flt_code = FC_SW;
        end else if (srv_evt) begin
          state_d = EN ? S_CLOSED : S_IDLE;
        end else if (cnt_q == CW'(OPEN_CYC - 1)) begin
          flt_set = 1'b1; flt_code = FC_TMO;
        end else if (!EN) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (CLRFLT && !FWOVR) state_d = S_IDLE;
      end
    endcase
    if (flt_set) state_d = S_FAULT;
  end

  always_comb begin
    wdfail_d = wdfail_q;
    flstat_d = flstat_q;
    if (flt_set) begin
      wdfail_d = 1'b1;
      flstat_d = flt_code;
    end else if (state_q == S_FAULT && state_d == S_IDLE) begin
      wdfail_d = 1'b0;
      flstat_d = FC_NONE;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    else if (cnt_q != '1)                        cnt_d = cnt_q + 1'b1;
  end

  // fired_q guards against a repeat pulse if the counter ever parks on RST_DLY-1
  always_comb begin
    rstreq_d = (state_q == S_FAULT) && (state_d == S_FAULT) &&
               (cnt_q == CW'(RST_DLY - 1)) && !fired_q;
    fired_d  = (state_q == S_FAULT) && (state_d == S_FAULT) && (fired_q || rstreq_d);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      srv_q    <= 1'b0;
      wdfail_q <= 1'b0;
      flstat_q <= FC_NONE;
      rstreq_q <= 1'b0;
      fired_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      srv_q    <= WDSRVC;
      wdfail_q <= wdfail_d;
      flstat_q <= flstat_d;
      rstreq_q <= rstreq_d;
      fired_q  <= fired_d;
    end
  end

`ifdef WD_FAULT_LOG_EN
  logic [7:0] fltcnt_q, fltcnt_d;

  always_comb begin
    fltcnt_d = fltcnt_q;
    if (flt_set && fltcnt_q != 8'hFF) fltcnt_d = fltcnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) fltcnt_q <= '0;
    else       fltcnt_q <= fltcnt_d;
  end

  assign FLTCNT = fltcnt_q;
`endif

  assign WDFAIL  = wdfail_q;
  assign FLSTAT  = flstat_q;
  assign WSTATE  = state_q;
  assign WINOPEN = (state_q == S_OPEN);
  assign RSTREQ  = rstreq_q;

endmodule

// File: tb/tb_wd_window_sequencer.sv
// Scoreboard bench for wd_window_sequencer: stimulus queues timed expectations, monitor checks them.
module tb_wd_window_sequencer;

  logic       CLK = 1'b0;
  logic       RSTN, EN, SWSTAT, WDSRVC, FWOVR, CLRFLT;
  logic       WDFAIL, WINOPEN, RSTREQ;
  logic [2:0] FLSTAT;
  logic [1:0] WSTATE;
`ifdef WD_FAULT_LOG_EN
  logic [7:0] FLTCNT;
`endif

  wd_window_sequencer dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .SWSTAT(SWSTAT), .WDSRVC(WDSRVC),
    .FWOVR(FWOVR), .CLRFLT(CLRFLT), .WDFAIL(WDFAIL), .FLSTAT(FLSTAT),
    .WSTATE(WSTATE), .WINOPEN(WINOPEN),
`ifdef WD_FAULT_LOG_EN
    .FLTCNT(FLTCNT),
`endif
    .RSTREQ(RSTREQ)
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] ID = 2'b00, CL = 2'b01, OP = 2'b10, FA = 2'b11;

  typedef struct {
    int         key;
    string      nm;
    logic [1:0] ws;
    logic       wf;
    logic [2:0] fl;
    logic       rr;
    bit         is_flt;
    logic [7:0] fc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // keys: 2*cycle for the post-posedge slot, 2*cycle+1 for the post-negedge slot
  task automatic push(input exp_t e);
    int i = 0;
    while (i < q.size() && q[i].key <= e.key) i++;
    q.insert(i, e);
  endtask

  task automatic expk(input int key, input string nm, input logic [1:0] ws,
                      input logic wf, input logic [2:0] fl, input logic rr);
    exp_t e;
    e.key = key; e.nm = nm; e.ws = ws; e.wf = wf; e.fl = fl; e.rr = rr;
    e.is_flt = 1'b0; e.fc = '0;
    push(e);
  endtask

  task automatic expn(input int n, input string nm, input logic [1:0] ws,
                      input logic wf, input logic [2:0] fl, input logic rr);
    expk(2 * (cyc + n), nm, ws, wf, fl, rr);
  endtask

  task automatic expf(input int key, input string nm, input logic [7:0] fc);
    exp_t e;
    e.key = key; e.nm = nm; e.ws = '0; e.wf = 1'b0; e.fl = '0; e.rr = 1'b0;
    e.is_flt = 1'b1; e.fc = fc;
    push(e);
  endtask

  task automatic check_slot(input int k);
    exp_t e;
    while (q.size() > 0 && q[0].key <= k) begin
      e = q.pop_front();
      n_chk++;
      if (e.key < k) begin
        n_fail++;
        $display("FAIL %s: check slot %0d missed, required by slot %0d", e.nm, k, e.key);
      end else if (e.is_flt) begin
`ifdef WD_FAULT_LOG_EN
        if (FLTCNT !== e.fc) begin
          n_fail++;
          $display("FAIL %s: FLTCNT got %0d expected %0d", e.nm, FLTCNT, e.fc);
        end
`endif
      end else if (WSTATE !== e.ws || WDFAIL !== e.wf || FLSTAT !== e.fl ||
                   RSTREQ !== e.rr || WINOPEN !== (e.ws == OP)) begin
        n_fail++;
        $display("FAIL %s: got ws=%0d wf=%0b fl=%03b wo=%0b rr=%0b expected ws=%0d wf=%0b fl=%03b wo=%0b rr=%0b",
                 e.nm, WSTATE, WDFAIL, FLSTAT, WINOPEN, RSTREQ,
                 e.ws, e.wf, e.fl, (e.ws == OP), e.rr);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK); #1 check_slot(2 * cyc);
      @(negedge CLK); #1 check_slot(2 * cyc + 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RSTN = 1'b0; EN = 1'b0; SWSTAT = 1'b0; WDSRVC = 1'b0; FWOVR = 1'b0; CLRFLT = 1'b0;
    tick(2);
    expk(2 * cyc + 1, "reset_state", ID, 1'b0, 3'b111, 1'b0);
    tick(1);
    RSTN = 1'b1;

    // normal window and mid-window kick
    EN = 1'b1; SWSTAT = 1'b1;
    expn(1, "idle_to_closed", CL, 1'b0, 3'b111, 1'b0);
    expn(16, "closed_last", CL, 1'b0, 3'b111, 1'b0);
    expn(17, "open_entry", OP, 1'b0, 3'b111, 1'b0);
    tick(17);
    tick(4);
    WDSRVC = 1'b1;
    expn(1, "kick", CL, 1'b0, 3'b111, 1'b0);
    tick(1);
    WDSRVC = 1'b0;
    expn(15, "reopen_early", CL, 1'b0, 3'b111, 1'b0);
    expn(16, "reopen", OP, 1'b0, 3'b111, 1'b0);
    tick(16);

    // window timeout, delayed reset request, EN ignored in FAULT
    expn(31, "open_last", OP, 1'b0, 3'b111, 1'b0);
    expn(32, "timeout", FA, 1'b1, 3'b011, 1'b0);
    expn(39, "tmo_pre_rstreq", FA, 1'b1, 3'b011, 1'b0);
    expn(40, "tmo_rstreq", FA, 1'b1, 3'b011, 1'b1);
    expn(41, "tmo_rstreq_once", FA, 1'b1, 3'b011, 1'b0);
    expn(60, "tmo_sticky_en0", FA, 1'b1, 3'b011, 1'b0);
    tick(33);
    EN = 1'b0;
    tick(30);
    CLRFLT = 1'b1;
    expn(1, "tmo_clear", ID, 1'b0, 3'b111, 1'b0);
    tick(1);
    CLRFLT = 1'b0;

    // early service in the closed window
    EN = 1'b1;
    expn(1, "early_closed", CL, 1'b0, 3'b111, 1'b0);
    tick(1);
    tick(2);
    WDSRVC = 1'b1;
    expn(1, "early_fault", FA, 1'b1, 3'b010, 1'b0);
    expn(8, "early_pre_rstreq", FA, 1'b1, 3'b010, 1'b0);
    expn(9, "early_rstreq", FA, 1'b1, 3'b010, 1'b1);
    expn(10, "early_rstreq_once", FA, 1'b1, 3'b010, 1'b0);
    tick(1);
    WDSRVC = 1'b0; EN = 1'b0;
    tick(11);
    CLRFLT = 1'b1;
    expn(1, "early_clear", ID, 1'b0, 3'b111, 1'b0);
    tick(1);
    CLRFLT = 1'b0;

    // override beats service; clear blocked while override held
    EN = 1'b1;
    tick(17);
    tick(2);
    FWOVR = 1'b1; WDSRVC = 1'b1;
    expn(1, "ovr_priority", FA, 1'b1, 3'b000, 1'b0);
    tick(1);
    WDSRVC = 1'b0; CLRFLT = 1'b1;
    expn(1, "clr_blocked_1", FA, 1'b1, 3'b000, 1'b0);
    expn(3, "clr_blocked_3", FA, 1'b1, 3'b000, 1'b0);
    tick(3);
    FWOVR = 1'b0;
    expn(1, "ovr_clear", ID, 1'b0, 3'b111, 1'b0);
    tick(1);
    CLRFLT = 1'b0; EN = 1'b0;

    // EN drop from CLOSED
    EN = 1'b1;
    tick(3);
    EN = 1'b0;
    expn(1, "en_off_closed", ID, 1'b0, 3'b111, 1'b0);
    tick(1);

    // service on the OPEN terminal cycle is a kick
    EN = 1'b1;
    tick(17);
    tick(31);
    WDSRVC = 1'b1;
    expn(1, "terminal_kick", CL, 1'b0, 3'b111, 1'b0);
    tick(1);
    WDSRVC = 1'b0; EN = 1'b0;
    expn(1, "en_off_after_kick", ID, 1'b0, 3'b111, 1'b0);
    tick(1);

    // closed-window service with SWSTAT low reports 001, not 010
    EN = 1'b1; SWSTAT = 1'b0;
    tick(3);
    WDSRVC = 1'b1;
    expn(1, "closed_sw_low", FA, 1'b1, 3'b001, 1'b0);
    tick(1);
    WDSRVC = 1'b0; EN = 1'b0; CLRFLT = 1'b1;
    expn(1, "closed_sw_clear", ID, 1'b0, 3'b111, 1'b0);
    tick(1);
    CLRFLT = 1'b0;

    // open-window service with SWSTAT low, then async reset mid-FAULT
    EN = 1'b1; SWSTAT = 1'b1;
    tick(17);
    SWSTAT = 1'b0; WDSRVC = 1'b1;
    expn(1, "open_sw_low", FA, 1'b1, 3'b001, 1'b0);
    expf(2 * (cyc + 1) + 1, "fltcnt_5", 8'd5);
    tick(1);
    WDSRVC = 1'b0;
    tick(1);
    RSTN = 1'b0; EN = 1'b0;
    expk(2 * cyc + 1, "async_reset", ID, 1'b0, 3'b111, 1'b0);
    expf(2 * cyc + 1, "fltcnt_reset", 8'd0);
    tick(2);
    RSTN = 1'b1;
    tick(1);

`ifdef WD_FAULT_LOG_EN
    for (int i = 0; i < 260; i++) begin
      FWOVR = 1'b1;
      tick(1);
      FWOVR = 1'b0; CLRFLT = 1'b1;
      tick(1);
      CLRFLT = 1'b0;
      if (i == 2) expf(2 * (cyc + 1), "fltcnt_3", 8'd3);
    end
    expf(2 * (cyc + 1), "fltcnt_sat", 8'd255);
    tick(2);
`endif

    tick(3);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: never checked, pending slot %0d", e.nm, e.key);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
